vga_fb_writer: RTL
==================

Name: vga_fb_writer

Overview:
- Write-side companion to the VGA scan-out reader. Accepts single-pixel writes and full-frame clears from the processor and stores them in the 18-bit-addressed, 16-bit-wide video memory in the layout the scan-out reader consumes.
- Packing: one word = two horizontally adjacent 8-bit pixels. High byte = even x, low byte = odd x. Colour fields in each byte: R[7:6], G[5:4], B[3:2]; bits [1:0] are stored as given.
- Memory accepts whole-word writes only, so every pixel write is a read-modify-write. The memory port is shared with other masters through a grant handshake.

Parameters:
- H_DISPLAY, 640, visible pixels per line; must be even.
- V_DISPLAY, 480, visible lines.
- WORDS_PER_LINE, 320, equal to H_DISPLAY/2.
- BEGIN_VIDEO_MEMORY, 18'h0, word address of pixel (0,0).

Ports:
- CLK, input, 1, single system clock; all logic on the rising edge.
- RESET, input, 1, asynchronous, active-high.
- REQ, input, 1, pixel write request; sampled only in IDLE.
- X, input, 10, pixel column.
- Y, input, 9, pixel row.
- COLOR, input, 8, pixel byte.
- CLEAR, input, 1, fill-frame request; sampled only in IDLE; uses COLOR.
- BUSY, output, 1, high in every state except IDLE.
- ACK, output, 1, one-cycle pulse when a command completes.
- ERR, output, 1, one-cycle pulse together with ACK when a pixel write is rejected.
- MEM_ADDRESS, output, 18, word address.
- MEM_WDATA, output, 16, write data.
- MEM_RDATA, input, 16, read data; valid the cycle after the read is granted.
- MEM_READ, output, 1, read strobe; held until granted.
- MEM_WRITE, output, 1, write strobe; held until granted.
- MEM_GRANT, input, 1, arbiter grant; a transfer completes on a rising edge where strobe and grant are both high.

Behaviour:
- Reset (asynchronous): state=IDLE. BUSY, ACK, ERR, MEM_READ, MEM_WRITE = 0. MEM_ADDRESS = BEGIN_VIDEO_MEMORY. MEM_WDATA = 0. Internal latches cleared.
- Reset mid-operation: strobes drop immediately. Any partial RMW is abandoned; no write is issued and no ACK is given.
- States: IDLE, CALC, RD, MERGE, WR, CLR, DONE.
- IDLE:
  - CLEAR=1 → latch COLOR, go to CLR. CLEAR has priority if REQ is also high.
  - Else REQ=1 → latch X, Y, COLOR, go to CALC.
  - ACK and ERR are 0.
- CALC:
  - If X ≥ H_DISPLAY or Y ≥ V_DISPLAY → DONE with ERR. No memory access.
  - Else MEM_ADDRESS = BEGIN_VIDEO_MEMORY + (Y<<8) + (Y<<6) + (X>>1), computed in 18-bit arithmetic, wrap permitted. Go to RD.
- RD: MEM_READ=1 and held. When MEM_GRANT is sampled high → MEM_READ=0, go to MERGE.
- MERGE:
  - Capture MEM_RDATA.
  - X[0]=0 → MEM_WDATA = {COLOR, RDATA[7:0]}.
  - X[0]=1 → MEM_WDATA = {RDATA[15:8], COLOR}.
  - Go to WR.
- WR: MEM_WRITE=1 and held, MEM_ADDRESS unchanged. When MEM_GRANT is sampled high → MEM_WRITE=0, go to DONE.
- CLR:
  - MEM_WDATA = {COLOR, COLOR}. MEM_WRITE=1 from address BEGIN_VIDEO_MEMORY.
  - On each granted cycle, advance the address by 1.
  - After the grant at BEGIN_VIDEO_MEMORY + WORDS_PER_LINE*V_DISPLAY − 1 (153599 at defaults) → MEM_WRITE=0, go to DONE.
  - Back-to-back grants give one word per cycle. No reads in this state.
- DONE: ACK=1 for one cycle, ERR as determined. Next state IDLE. The next command can be accepted in the cycle after DONE.
- Latency, with MEM_GRANT tied high: acceptance edge → ACK asserted 5 cycles later for a pixel write (CALC, RD, MERGE, WR, DONE).
- Clear latency: 153600 write cycles + 2.
- Inputs X/Y/COLOR/REQ/CLEAR are ignored while BUSY. Only one write is performed per request, even if REQ is held high through completion; if REQ is still high in IDLE, a new command is accepted.
- MEM_READ and MEM_WRITE are never high in the same cycle.
- MEM_GRANT while no strobe is high has no effect.

Test Plan:
- Reset then idle, GRANT=1: all outputs 0, MEM_ADDRESS=0; REQ/CLEAR pulsed during RESET are ignored.
- Memory word 0 = 16'hABCD. REQ X=0 Y=0 COLOR=8'h12 → read addr 0, write addr 0 data 16'h12CD, ACK 5 cycles after acceptance. Then REQ X=1 COLOR=8'h34 → write 16'h1234.
- REQ X=639 Y=479 → address 153599, low byte replaced. REQ X=640 Y=0 → no MEM_READ/MEM_WRITE, ACK+ERR after 2 cycles.
- GRANT held low for 7 cycles during RD and again during WR → strobes and address stay stable throughout, exactly one read and one write, ACK after the grants.
- CLEAR with COLOR=8'hE0, REQ also high → clear wins: 153600 writes of 16'hE0E0 to addresses 0..153599, then a single ACK; the pending REQ is serviced afterwards.
- RESET asserted during WR with GRANT=0 → MEM_WRITE drops asynchronously, memory unchanged, no ACK; the next command after release completes normally.

Source files
------------

// File: rtl/vga_fb_writer.sv
// Write-side framebuffer engine: single-pixel read-modify-write and full-frame
// clear into 16-bit video memory holding two 8-bit pixels per word.
module vga_fb_writer #(
  parameter int          H_DISPLAY          = 640,
  parameter int          V_DISPLAY          = 480,
  parameter int          WORDS_PER_LINE     = 320,
  parameter logic [17:0] BEGIN_VIDEO_MEMORY = 18'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic [7:0]  i_color,
  input  logic        i_clear,
  output logic        o_busy,
  output logic        o_ack,
  output logic        o_err,
  output logic [17:0] o_mem_address,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  output logic        o_mem_read,
  output logic        o_mem_write,
  input  logic        i_mem_grant
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RD,
    S_MERGE,
    S_WR,
    S_CLR,
    S_DONE
  } state_t;

  localparam logic [17:0] LAST_ADDR =
    BEGIN_VIDEO_MEMORY + 18'(WORDS_PER_LINE * V_DISPLAY - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [7:0]  r_color;
  logic        r_err;
  logic [17:0] r_addr;
  logic [15:0] r_wdata;

  logic        w_out_of_range;
  logic [17:0] w_calc_addr;
  logic [17:0] w_y_ext;

  assign w_out_of_range = ({22'd0, r_x} >= 32'(H_DISPLAY)) ||
                          ({23'd0, r_y} >= 32'(V_DISPLAY));

  // Row offset y*320 built from shifts; 18-bit wrap is intentional.
  assign w_y_ext     = {9'd0, r_y};
  assign w_calc_addr = BEGIN_VIDEO_MEMORY + (w_y_ext << 8) + (w_y_ext << 6)
                     + {9'd0, r_x[9:1]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_clear) begin
          w_state_next = S_CLR;
        end else if (i_req) begin
          w_state_next = S_CALC;
        end
      end
      S_CALC:  w_state_next = w_out_of_range ? S_DONE : S_RD;
      S_RD:    if (i_mem_grant) w_state_next = S_MERGE;
      S_MERGE: w_state_next = S_WR;
      S_WR:    if (i_mem_grant) w_state_next = S_DONE;
      S_CLR:   if (i_mem_grant && (r_addr == LAST_ADDR)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_err   <= 1'b0;
      r_addr  <= BEGIN_VIDEO_MEMORY;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_clear) begin
            r_color <= i_color;
            r_err   <= 1'b0;
            r_addr  <= BEGIN_VIDEO_MEMORY;
            r_wdata <= {i_color, i_color};
          end else if (i_req) begin
            r_x     <= i_x;
            r_y     <= i_y;
            r_color <= i_color;
            r_err   <= 1'b0;
          end
        end
        S_CALC: begin
          if (w_out_of_range) begin
            r_err <= 1'b1;
          end else begin
            r_addr <= w_calc_addr;
          end
        end
        // Even x lives in the high byte, odd x in the low byte.
        S_MERGE: begin
          r_wdata <= r_x[0] ? {i_mem_rdata[15:8], r_color}
                            : {r_color, i_mem_rdata[7:0]};
        end
        S_CLR: begin
          if (i_mem_grant && (r_addr != LAST_ADDR)) begin
            r_addr <= r_addr + 18'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state so a reset drops them at once.
  assign o_busy        = (r_state != S_IDLE);
  assign o_ack         = (r_state == S_DONE);
  assign o_err         = (r_state == S_DONE) && r_err;
  assign o_mem_read    = (r_state == S_RD);
  assign o_mem_write   = (r_state == S_WR) || (r_state == S_CLR);
  assign o_mem_address = r_addr;
  assign o_mem_wdata   = r_wdata;

endmodule
